// File: rtl/vape_boundary_mc_pkg.sv
// vape_pkg: shared state encoding, abort-cause bit positions and default address width for the VAPE boundary monitor.
package vape_pkg;
    localparam int VAPE_ADDR_W = 16;
    localparam int CAUSE_WR = 0;
    localparam int CAUSE_CFG = 1;
    typedef enum logic {VAPE_ABORT = 1'b0, VAPE_EXEC = 1'b1} vape_state_e;
endpackage

// File: rtl/vape_boundary_mc_if.sv
// vape_boundary_mc_if: monitor bus bundle; abort_cnt exists only when VAPE_ABORT_CNT_EN is defined.
interface vape_boundary_mc_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = vape_pkg::VAPE_ADDR_W
`ifdef VAPE_ABORT_CNT_EN
    , parameter int CNT_W = 8
`endif
);
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] data_addr;
    logic data_en;
    logic [ADDR_W-1:0] dma_addr;
    logic dma_en;
    logic [NUM_CH*ADDR_W-1:0] er_min;
    logic [NUM_CH*ADDR_W-1:0] meta_min;
    logic [NUM_CH*ADDR_W-1:0] meta_max;
    logic [NUM_CH-1:0] cause_clr;
    logic [NUM_CH-1:0] exec;
    logic [2*NUM_CH-1:0] abort_cause;
`ifdef VAPE_ABORT_CNT_EN
    logic [NUM_CH*CNT_W-1:0] abort_cnt;
`endif
    modport master (
        output pc, data_addr, data_en, dma_addr, dma_en, er_min, meta_min, meta_max, cause_clr,
        input exec, abort_cause
`ifdef VAPE_ABORT_CNT_EN
        , input abort_cnt
`endif
    );
    modport slave (
        input pc, data_addr, data_en, dma_addr, dma_en, er_min, meta_min, meta_max, cause_clr,
        output exec, abort_cause
`ifdef VAPE_ABORT_CNT_EN
        , output abort_cnt
`endif
    );
endinterface

// File: rtl/vape_boundary_mc_ch.sv
// vape_boundary_ch: one channel's window compare, EXEC/ABORT FSM, bounds history, sticky cause and optional abort counter (VAPE_ABORT_CNT_EN).
module vape_boundary_ch
    import vape_pkg::*;
#(
    parameter int ADDR_W = VAPE_ADDR_W
`ifdef VAPE_ABORT_CNT_EN
    , parameter int CNT_W = 8
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic data_en,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic dma_en,
    input  logic [ADDR_W-1:0] er_min,
    input  logic [ADDR_W-1:0] meta_min,
    input  logic [ADDR_W-1:0] meta_max,
    input  logic cause_clr,
    output logic exec,
    output logic [1:0] cause
`ifdef VAPE_ABORT_CNT_EN
    , output logic [CNT_W-1:0] cnt
`endif
);
    vape_state_e state, state_nx;
    logic [ADDR_W-1:0] prev_er, prev_min, prev_max;
    logic prev_vld, wr, cfg_chg, bad, kill, abort_ev;
    logic [1:0] cause_nx;
    assign wr = (data_en && data_addr >= meta_min && data_addr <= meta_max) ||
                (dma_en && dma_addr >= meta_min && dma_addr <= meta_max);
    assign cfg_chg = prev_vld && {er_min, meta_min, meta_max} != {prev_er, prev_min, prev_max};
    assign bad = meta_min > meta_max;
    assign kill = wr || cfg_chg || bad;
    assign abort_ev = state == VAPE_EXEC && kill;
    assign exec = state == VAPE_EXEC;
    always_comb begin
        state_nx = state == VAPE_EXEC ? (kill ? VAPE_ABORT : VAPE_EXEC)
                                      : (pc == er_min && !kill ? VAPE_EXEC : VAPE_ABORT);
        cause_nx = cause_clr ? 2'b00 : cause;
        cause_nx[CAUSE_WR] = cause_nx[CAUSE_WR] | (abort_ev & wr);
        cause_nx[CAUSE_CFG] = cause_nx[CAUSE_CFG] | (abort_ev & cfg_chg);
    end
    // prev_vld masks the first edge after reset so initial bounds never count as a change
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= VAPE_ABORT;
            cause <= '0;
            prev_vld <= 1'b0;
            prev_er <= '0;
            prev_min <= '0;
            prev_max <= '0;
        end else begin
            state <= state_nx;
            cause <= cause_nx;
            prev_vld <= 1'b1;
            prev_er <= er_min;
            prev_min <= meta_min;
            prev_max <= meta_max;
        end
    end
`ifdef VAPE_ABORT_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else if (abort_ev && cnt != '1) cnt <= cnt + 1'b1;
    end
`endif
endmodule

// File: rtl/vape_boundary_mc.sv
// vape_boundary_mc: NUM_CH independent execution/metadata boundary monitors over flattened buses.
// Optional per-channel abort counters are enabled with VAPE_ABORT_CNT_EN.
module vape_boundary_mc
    import vape_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = VAPE_ADDR_W,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic reset_n,
    vape_boundary_mc_if.slave bus
);
    if (NUM_CH < 1 || NUM_CH > 8 || CNT_W < 1) begin : g_bad_cfg
        $error("vape_boundary_mc: NUM_CH must be 1..8 and CNT_W >= 1");
    end
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        vape_boundary_ch #(
            .ADDR_W(ADDR_W)
`ifdef VAPE_ABORT_CNT_EN
            , .CNT_W(CNT_W)
`endif
        ) u_ch (
            .clk(clk),
            .reset_n(reset_n),
            .pc(bus.pc),
            .data_addr(bus.data_addr),
            .data_en(bus.data_en),
            .dma_addr(bus.dma_addr),
            .dma_en(bus.dma_en),
            .er_min(bus.er_min[i*ADDR_W +: ADDR_W]),
            .meta_min(bus.meta_min[i*ADDR_W +: ADDR_W]),
            .meta_max(bus.meta_max[i*ADDR_W +: ADDR_W]),
            .cause_clr(bus.cause_clr[i]),
            .exec(bus.exec[i]),
            .cause(bus.abort_cause[2*i +: 2])
`ifdef VAPE_ABORT_CNT_EN
            , .cnt(bus.abort_cnt[i*CNT_W +: CNT_W])
`endif
        );
    end
endmodule

// File: tb/tb_vape_boundary_mc.sv
// tb_vape_boundary_mc: vector table plus scoreboard checks of the four-channel boundary monitor.
module tb_vape_boundary_mc;
    localparam int NC = 4;
    localparam int AW = 16;
    localparam int CW = 2;
    localparam logic [15:0] IDLE = 16'h8000;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;
    vape_boundary_mc_if #(
        .NUM_CH(NC), .ADDR_W(AW)
`ifdef VAPE_ABORT_CNT_EN
        , .CNT_W(CW)
`endif
    ) bus ();
    vape_boundary_mc #(.NUM_CH(NC), .ADDR_W(AW), .CNT_W(CW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    typedef struct {
        logic [15:0] pc;
        logic [15:0] da;
        logic de;
        logic [15:0] ma;
        logic me;
        logic [15:0] mmax0;
        logic [3:0] clr;
        logic [3:0] ex;
        logic [7:0] ca;
    } vec_t;
    typedef struct {
        logic [3:0] ex;
        logic [7:0] ca;
    } exp_t;
    exp_t sb[$];
    vec_t tbl[22];
    int n_chk = 0;
    int n_pass = 0;
    function automatic vec_t mk(input logic [15:0] pc, da, input logic de, input logic [15:0] ma,
                                input logic me, input logic [15:0] mmax0, input logic [3:0] clr,
                                input logic [3:0] ex, input logic [7:0] ca);
        vec_t v;
        v.pc = pc; v.da = da; v.de = de; v.ma = ma; v.me = me;
        v.mmax0 = mmax0; v.clr = clr; v.ex = ex; v.ca = ca;
        return v;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    task automatic step(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        bus.pc = v.pc;
        bus.data_addr = v.da;
        bus.data_en = v.de;
        bus.dma_addr = v.ma;
        bus.dma_en = v.me;
        bus.meta_max[15:0] = v.mmax0;
        bus.cause_clr = v.clr;
        sb.push_back('{ex: v.ex, ca: v.ca});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, " exec"}, 32'(bus.exec), 32'(e.ex));
        chk({tag, " cause"}, 32'(bus.abort_cause), 32'(e.ca));
    endtask
    initial begin
        bus.er_min = {16'hFFF0, 16'h3000, 16'h1000, 16'hE000};
        bus.meta_min = {16'hFF00, 16'hF080, 16'h0000, 16'hF000};
        bus.meta_max = {16'hFFFF, 16'hF17F, 16'h00FF, 16'hF0FF};
        bus.pc = IDLE; bus.data_addr = '0; bus.data_en = 0;
        bus.dma_addr = '0; bus.dma_en = 0; bus.cause_clr = '0;
        tbl[0]  = mk(IDLE,    16'h0,    0, 16'h0,    0, 16'hF0FF, 4'h0, 4'b0000, 8'h00);
        tbl[1]  = mk(16'hE000, 16'h0,    0, 16'h0,    0, 16'hF0FF, 4'h0, 4'b0001, 8'h00);
        tbl[2]  = mk(IDLE,    16'h0,    0, 16'h0,    0, 16'hF0FF, 4'h0, 4'b0001, 8'h00);
        tbl[3]  = mk(16'h1000, 16'h0,    0, 16'h0,    0, 16'hF0FF, 4'h0, 4'b0011, 8'h00);
        tbl[4]  = mk(16'h3000, 16'h0,    0, 16'h0,    0, 16'hF0FF, 4'h0, 4'b0111, 8'h00);
        tbl[5]  = mk(16'hFFF0, 16'h0,    0, 16'h0,    0, 16'hF0FF, 4'h0, 4'b1111, 8'h00);
        tbl[6]  = mk(IDLE,    16'hF100, 1, 16'h0,    0, 16'hF0FF, 4'h0, 4'b1011, 8'h10);
        tbl[7]  = mk(IDLE,    16'hF0FF, 1, 16'h0,    0, 16'hF0FF, 4'h0, 4'b1010, 8'h11);
        tbl[8]  = mk(16'h3000, 16'h0,    0, 16'h0,    0, 16'hF0FF, 4'h0, 4'b1110, 8'h11);
        tbl[9]  = mk(IDLE,    16'h0,    0, 16'hFFFF, 1, 16'hF0FF, 4'h0, 4'b0110, 8'h51);
        tbl[10] = mk(IDLE,    16'h0,    0, 16'h0000, 1, 16'hF0FF, 4'h0, 4'b0100, 8'h55);
        tbl[11] = mk(16'hE000, 16'h0,    0, 16'hF000, 1, 16'hF0FF, 4'h0, 4'b0100, 8'h55);
        tbl[12] = mk(IDLE,    16'h0,    0, 16'h0,    0, 16'hF0FF, 4'hF, 4'b0100, 8'h00);
        tbl[13] = mk(16'hE000, 16'h0,    0, 16'h0,    0, 16'hF0FF, 4'h0, 4'b0101, 8'h00);
        tbl[14] = mk(IDLE,    16'hF0A0, 1, 16'h0,    0, 16'hF0FF, 4'h0, 4'b0000, 8'h11);
        tbl[15] = mk(16'hE000, 16'h0,    0, 16'h0,    0, 16'hF0FF, 4'h1, 4'b0001, 8'h10);
        tbl[16] = mk(IDLE,    16'h0,    0, 16'h0,    0, 16'hF1FF, 4'h0, 4'b0000, 8'h12);
        tbl[17] = mk(IDLE,    16'h0,    0, 16'h0,    0, 16'hF1FF, 4'h0, 4'b0000, 8'h12);
        tbl[18] = mk(16'hE000, 16'h0,    0, 16'h0,    0, 16'hF1FF, 4'h0, 4'b0001, 8'h12);
        tbl[19] = mk(IDLE,    16'hF150, 1, 16'h0,    0, 16'hF1FF, 4'h1, 4'b0000, 8'h11);
        tbl[20] = mk(IDLE,    16'h0,    0, 16'h0,    0, 16'hF0FF, 4'h0, 4'b0000, 8'h11);
        tbl[21] = mk(16'hE000, 16'h0,    0, 16'h0,    0, 16'hF0FF, 4'h0, 4'b0001, 8'h11);
        #1;
        chk("reset exec", 32'(bus.exec), 32'h0);
        chk("reset cause", 32'(bus.abort_cause), 32'h0);
        #11 reset_n = 1'b1;
        for (int i = 0; i < 22; i++) step(tbl[i], $sformatf("vec%0d", i));
        // asynchronous reset while ch0 is in EXEC, sampled before any further clock edge
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset exec", 32'(bus.exec), 32'h0);
        chk("async reset cause", 32'(bus.abort_cause), 32'h0);
`ifdef VAPE_ABORT_CNT_EN
        chk("async reset cnt", 32'(bus.abort_cnt), 32'h0);
`endif
        bus.pc = IDLE; bus.data_en = 0; bus.dma_en = 0; bus.cause_clr = '0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(mk(16'hE000, 16'h0, 0, 16'h0, 0, 16'hF0FF, 4'h0, 4'b0001, k == 1 ? 8'h00 : 8'h01),
                 $sformatf("cnt enter%0d", k));
            step(mk(IDLE, 16'hF000, 1, 16'h0, 0, 16'hF0FF, 4'h0, 4'b0000, 8'h01),
                 $sformatf("cnt kill%0d", k));
`ifdef VAPE_ABORT_CNT_EN
            chk($sformatf("abort_cnt after %0d", k), 32'(bus.abort_cnt), k < 3 ? k : 3);
`endif
        end
        bus.meta_min[15:0] = 16'hF100;
        step(mk(16'hE000, 16'h0, 0, 16'h0, 0, 16'hF000, 4'h0, 4'b0000, 8'h01), "bad bounds a");
        step(mk(16'hE000, 16'h0, 0, 16'h0, 0, 16'hF000, 4'h0, 4'b0000, 8'h01), "bad bounds b");
        bus.meta_min[15:0] = 16'hF000;
        step(mk(IDLE, 16'h0, 0, 16'h0, 0, 16'hF0FF, 4'h0, 4'b0000, 8'h01), "restore bounds");
        step(mk(16'hE000, 16'h0, 0, 16'h0, 0, 16'hF0FF, 4'h0, 4'b0001, 8'h01), "reentry");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
